// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, flush-to-bubble and a saturating squash counter.
// Define PIPE_SKID_EN to add a skid entry so that in_ready comes straight from a flop.
module pipe_stage_reg #(
  parameter int unsigned        DATA_W      = 96,
  parameter int unsigned        CTRL_W      = 16,
  parameter logic [CTRL_W-1:0]  CTRL_BUBBLE = {CTRL_W{1'b0}},
  parameter int unsigned        KILL_W      = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [KILL_W-1:0] kill_cnt
);

  function automatic logic [KILL_W-1:0] sat_add(input logic [KILL_W-1:0] cnt,
                                                input logic [1:0]        inc);
    logic [KILL_W:0] sum;
    sum = {1'b0, cnt} + {{(KILL_W-1){1'b0}}, inc};
    if (sum[KILL_W]) begin
      return {KILL_W{1'b1}};
    end else begin
      return sum[KILL_W-1:0];
    end
  endfunction

  logic              main_valid_q, main_valid_d;
  logic [CTRL_W-1:0] main_ctrl_q,  main_ctrl_d;
  logic [DATA_W-1:0] main_data_q,  main_data_d;
  logic [KILL_W-1:0] kill_cnt_q,   kill_cnt_d;
  logic              skid_valid_q, skid_valid_d;
  logic [CTRL_W-1:0] skid_ctrl_q,  skid_ctrl_d;
  logic [DATA_W-1:0] skid_data_q,  skid_data_d;
  logic              main_free_s;
  logic              xfer_in_s;
  logic              xfer_out_s;
  logic [1:0]        killed_s;

  assign main_free_s = ~main_valid_q | out_ready;
  assign xfer_in_s   = in_valid & in_ready & ~flush;
  assign xfer_out_s  = main_valid_q & out_ready;

`ifdef PIPE_SKID_EN
  assign in_ready = ~skid_valid_q;
`else
  assign in_ready = main_free_s;
`endif

  // Next-state for main/skid entries and the squash counter.
  always_comb begin
    main_valid_d = main_valid_q;
    main_ctrl_d  = main_ctrl_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_ctrl_d  = skid_ctrl_q;
    skid_data_d  = skid_data_q;
    kill_cnt_d   = kill_cnt_q;
    killed_s     = 2'd0;
    if (flush) begin
      // An entry consumed downstream in the flush cycle is not a kill.
      killed_s     = {1'b0, main_valid_q & ~out_ready} + {1'b0, skid_valid_q};
      kill_cnt_d   = sat_add(kill_cnt_q, killed_s);
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else begin
`ifdef PIPE_SKID_EN
      if (skid_valid_q) begin
        if (out_ready) begin
          main_ctrl_d  = skid_ctrl_q;
          main_data_d  = skid_data_q;
          skid_valid_d = 1'b0;
        end else begin
          skid_valid_d = 1'b1;
        end
      end else if (xfer_in_s) begin
        if (main_free_s) begin
          main_valid_d = 1'b1;
          main_ctrl_d  = in_ctrl;
          main_data_d  = in_data;
        end else begin
          skid_valid_d = 1'b1;
          skid_ctrl_d  = in_ctrl;
          skid_data_d  = in_data;
        end
      end else if (xfer_out_s) begin
        main_valid_d = 1'b0;
      end else begin
        main_valid_d = main_valid_q;
      end
`else
      if (xfer_in_s) begin
        main_valid_d = 1'b1;
        main_ctrl_d  = in_ctrl;
        main_data_d  = in_data;
      end else if (xfer_out_s) begin
        main_valid_d = 1'b0;
      end else begin
        main_valid_d = main_valid_q;
      end
`endif
    end
  end

  // State registers, cleared asynchronously by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_valid_q <= 1'b0;
      main_ctrl_q  <= CTRL_BUBBLE;
      main_data_q  <= {DATA_W{1'b0}};
      skid_valid_q <= 1'b0;
      skid_ctrl_q  <= CTRL_BUBBLE;
      skid_data_q  <= {DATA_W{1'b0}};
      kill_cnt_q   <= {KILL_W{1'b0}};
    end else begin
      main_valid_q <= main_valid_d;
      main_ctrl_q  <= main_ctrl_d;
      main_data_q  <= main_data_d;
      skid_valid_q <= skid_valid_d;
      skid_ctrl_q  <= skid_ctrl_d;
      skid_data_q  <= skid_data_d;
      kill_cnt_q   <= kill_cnt_d;
    end
  end

  // Bubble forced from valid so a stale payload never reaches the next stage.
  assign out_valid = main_valid_q;
  assign out_ctrl  = main_valid_q ? main_ctrl_q : CTRL_BUBBLE;
  assign out_data  = main_valid_q ? main_data_q : {DATA_W{1'b0}};
  assign kill_cnt  = kill_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Randomized self-checking bench for pipe_stage_reg against a queue-based occupancy model.
module tb_pipe_stage_reg;
  localparam int DW = 96;
  localparam int CW = 16;
  localparam int KW = 2;
  localparam int KMAX = 3;
`ifdef PIPE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [CW-1:0] in_ctrl = '0;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_data;
  logic [KW-1:0] kill_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  logic [CW-1:0] mq_c[$];
  logic [DW-1:0] mq_d[$];
  int            m_kill = 0;

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CTRL_BUBBLE(16'h0000), .KILL_W(KW)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
    .kill_cnt(kill_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Capacity rule: without skid a full stage only accepts while draining.
  function automatic bit exp_ready();
    if (CAP == 2) return mq_c.size() < 2;
    else          return (mq_c.size() == 0) || out_ready;
  endfunction

  function automatic logic [DW-1:0] rnd_data();
    return {$urandom, $urandom, $urandom};
  endfunction

  task automatic cycle(input bit iv, input bit fl, input bit ordy,
                       input logic [CW-1:0] c, input logic [DW-1:0] d);
    bit acc;
    int k;
    in_valid = iv; flush = fl; out_ready = ordy; in_ctrl = c; in_data = d;
    @(negedge clk);
    chk("out_valid", out_valid, mq_c.size() > 0);
    chk("out_ctrl", out_ctrl, (mq_c.size() > 0) ? mq_c[0] : 16'h0000);
    chk("out_data", out_data, (mq_d.size() > 0) ? mq_d[0] : 96'h0);
    chk("in_ready", in_ready, exp_ready());
    chk("kill_cnt", kill_cnt, m_kill);
    @(posedge clk);
    if (fl) begin
      k = mq_c.size();
      if (k > 0 && ordy) k--;
      m_kill = (m_kill + k > KMAX) ? KMAX : m_kill + k;
      mq_c.delete(); mq_d.delete();
    end else begin
      acc = iv && exp_ready();
      if (mq_c.size() > 0 && ordy) begin
        void'(mq_c.pop_front()); void'(mq_d.pop_front());
      end
      if (acc) begin
        mq_c.push_back(c); mq_d.push_back(d);
      end
    end
    #1;
  endtask

  // Reset raised between edges; outputs must clear before the next clock edge.
  task automatic async_reset();
    #2 reset = 1'b1;
    #1;
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_ctrl", out_ctrl, 16'h0000);
    chk("rst_data", out_data, 96'h0);
    chk("rst_kill", kill_cnt, 2'd0);
    chk("rst_ready", in_ready, 1'b1);
    mq_c.delete(); mq_d.delete(); m_kill = 0;
    reset = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] a_d;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // First transfer and 8-word back-to-back stream
    cycle(1'b1, 1'b0, 1'b1, 16'h00A5, 96'h1234);
    chk("t1_valid", out_valid, 1'b1);
    chk("t1_ctrl", out_ctrl, 16'h00A5);
    chk("t1_data", out_data, 96'h1234);
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 1'b1, 16'(i + 16), rnd_data());
    cycle(1'b0, 1'b0, 1'b1, 16'h0, 96'h0);
    cycle(1'b0, 1'b0, 1'b1, 16'h0, 96'h0);

    // Stall holds A; skid takes B only
    a_d = rnd_data();
    cycle(1'b1, 1'b0, 1'b0, 16'h00AA, a_d);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 16'h00BB, 96'hB);
      chk("stall_data", out_data, a_d);
    end
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1, 16'h0, 96'h0);

    // Flush of a full stage with same-cycle input
    cycle(1'b1, 1'b0, 1'b0, 16'h0011, rnd_data());
    cycle(1'b1, 1'b0, 1'b0, 16'h0022, rnd_data());
    cycle(1'b1, 1'b1, 1'b0, 16'h0033, rnd_data());
    chk("fl_valid", out_valid, 1'b0);
    chk("fl_data", out_data, 96'h0);
    chk("fl_kill", kill_cnt, CAP);
    for (int i = 0; i < 2; i++) cycle(1'b0, 1'b0, 1'b1, 16'h0, 96'h0);

    // Flush while draining: consumed entry not counted
    cycle(1'b1, 1'b0, 1'b1, 16'h0044, rnd_data());
    cycle(1'b0, 1'b1, 1'b1, 16'h0, 96'h0);
    chk("fl_drain_kill", kill_cnt, CAP);

    // Saturation with KILL_W=2: 1,2,3,3,3
    cycle(1'b0, 1'b0, 1'b1, 16'h0, 96'h0);
    async_reset();
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 16'(i), rnd_data());
      cycle(1'b0, 1'b1, 1'b0, 16'h0, 96'h0);
      chk("sat_kill", kill_cnt, (i < 3) ? i + 1 : 3);
    end

    // Async reset mid-stall with the stage full
    cycle(1'b1, 1'b0, 1'b0, 16'h0055, rnd_data());
    cycle(1'b1, 1'b0, 1'b0, 16'h0066, rnd_data());
    cycle(1'b1, 1'b0, 1'b0, 16'h0077, rnd_data());
    async_reset();
    cycle(1'b1, 1'b0, 1'b1, 16'h0088, 96'h88);
    chk("post_rst_ctrl", out_ctrl, 16'h0088);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0,
            $urandom_range(0, 9) < 6, 16'($urandom), rnd_data());
      if ($urandom_range(0, 199) == 0) async_reset();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register carrying an opaque control word and a data word between two processor pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB). Unlike the fixed per-stage registers, it has a valid/ready handshake with true hold-on-stall, a separate flush that inserts a bubble, and a saturating count of squashed instructions for debug. An optional skid entry registers the upstream ready path for timing closure.

## Interface
- DATA_W, 96, width of the data payload (operands, immediate, PC+4, ...)
- CTRL_W, 16, width of the control payload (RegWrite, MemRead, ALUOp, ...)
- CTRL_BUBBLE, {CTRL_W{1'b0}}, control value presented while the stage holds a bubble
- KILL_W, 8, width of the squash counter
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- flush  in  1  synchronous squash of every held entry and any same-cycle input
- in_valid  in  1  upstream stage presents an instruction
- in_ready  out  1  this stage accepts in the current cycle
- in_ctrl  in  CTRL_W  upstream control payload
- in_data  in  DATA_W  upstream data payload
- out_valid  out  1  downstream payload valid
- out_ready  in  1  downstream consumes when out_valid=1
- out_ctrl  out  CTRL_W  CTRL_BUBBLE when out_valid=0, else held control
- out_data  out  DATA_W  zero when out_valid=0, else held data
- kill_cnt  out  KILL_W  saturating count of valid entries destroyed by flush

## Operation
- Transfer in: in_valid & in_ready & !flush. Transfer out: out_valid & out_ready.
- Main entry: loads on transfer in when empty or draining in the same cycle; otherwise holds (stall = out_valid & !out_ready keeps contents unchanged, no bubble).
- Main empties on transfer out with no transfer in; out_ctrl returns to CTRL_BUBBLE, out_data to 0.
- flush (priority over all but reset): every entry invalidated, out_valid=0 next cycle, same-cycle input dropped even if in_ready=1, in_ready unaffected in flush cycle.
- kill_cnt += number of valid entries held at the flush edge (0, 1, or 2 with skid); saturates at 2^KILL_W-1, never wraps.
- Bubble outputs are forced combinationally from valid, so stale payload never leaks downstream.

## Timing
- Reset values: out_valid=0, out_ctrl=CTRL_BUBBLE, out_data=0, kill_cnt=0, in_ready=1, skid empty.
- Latency: 1 cycle from transfer in to out_valid=1; throughput 1 per cycle under continuous out_ready=1.
- Without skid: in_ready = !out_valid | out_ready (combinational from out_ready).
- Reset asserted mid-stall or mid-flush: all state cleared immediately; first transfer possible on first edge after deassertion.
- flush and transfer out in the same cycle: downstream consumes the entry (not counted as killed); other entries killed.

## Configuration
- PIPE_SKID_EN defined: one extra skid entry; in_ready = !skid_valid (pure flop output, no path from out_ready). Input arriving while main is full and not draining goes to skid; when main drains, skid moves to main next edge and in_ready rises. Order strictly preserved. Full-rate throughput retained.
- PIPE_SKID_EN undefined: no skid storage; combinational in_ready as above; kill_cnt increments by at most 1.

## Test plan
- Reset then in_valid=1, in_ctrl=16'h00A5, in_data=96'h1234, out_ready=1 -> next cycle out_valid=1, out_ctrl=16'h00A5, out_data=96'h1234; back-to-back stream of 8 words emerges one per cycle in order.
- Load word A, hold out_ready=0 for 5 cycles -> out_valid=1, payload A constant all 5 cycles; without skid in_ready=0 throughout; with skid one extra word B accepted then in_ready=0; release -> A then B.
- Full stage, flush=1 with in_valid=1 -> next cycle out_valid=0, out_ctrl=CTRL_BUBBLE, out_data=0, kill_cnt=1 (2 with skid full), flushed input never appears.
- flush and out_ready=1 on a valid entry same cycle -> entry consumed, kill_cnt unchanged.
- KILL_W=2, 5 flushes on full stage -> kill_cnt 1,2,3,3,3.
- Assert reset asynchronously mid-stall with skid full -> outputs at reset values before next clk edge; no old payload after release.
